march_bist_ctrl: RTL and testbench

- Built-in self-test initiator for the single-port RAM in the BIST block.
- Drives address, write enable and read enable, and owns the shared bidirectional data bus whenever it writes.
- Runs a March C- sequence on start and reports pass/fail plus the first failing address and data.
- Sits between the CPU test/config logic (start/done/fail) and the RAM's clk/adress/data/wr_en/read_en pins.

---
 rtl/march_bist_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_march_bist_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/march_bist_ctrl.sv
// march_bist_ctrl
//   March C- built-in self-test initiator for a single-port RAM.
//   On an accepted start it runs E0..E5 (w0 / r0,w1 / r1,w0 / v r0,w1 /
//   v r1,w0 / r0). It performs one RAM operation per clock, 10*2^Adr_size
//   cycles in total, and reports pass/fail plus the first failing address
//   and the data read there.
//
//   Optional build macro: BIST_STOP_ON_FAIL_EN
//     defined   -> the first mismatch ends the run at that edge, and adress
//                  holds the failing address.
//     undefined -> the full sequence always runs.
//
// Ports
//   clk       in   system clock, posedge
//   rst       in   synchronous active-high reset
//   start     in   one-cycle pulse, accepted in IDLE or DONE
//   adress    out  RAM address (registered)
//   data      io   RAM data bus, driven only while wr_en=1
//   wr_en     out  RAM write enable (registered)
//   read_en   out  RAM read enable (registered)
//   busy      out  high while the sequence runs
//   done      out  sticky completion flag
//   fail      out  sticky mismatch flag
//   fail_adr  out  address of the first mismatch
//   fail_data out  data read at the first mismatch
module march_bist_ctrl #(
   parameter int Dta_size = 8,
   parameter int Adr_size = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic [Adr_size-1:0] adress,
   inout  logic [Dta_size-1:0] data,
   output logic                wr_en,
   output logic                read_en,
   output logic                busy,
   output logic                done,
   output logic                fail,
   output logic [Adr_size-1:0] fail_adr,
   output logic [Dta_size-1:0] fail_data
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_e;

   state_e              state_q;
   elem_e               elem_q;
   logic                op2_q;      // second operation of a two-op element
   logic [Adr_size-1:0] adr_q;
   logic                wr_q;
   logic                rd_q;
   logic [Dta_size-1:0] wdata_q;
   logic                busy_q;
   logic                done_q;
   logic                fail_q;
   logic [Adr_size-1:0] fail_adr_q;
   logic [Dta_size-1:0] fail_data_q;

   // Next-operation values, computed from the operation on the pins now
   elem_e               elem_d;
   logic                op2_d;
   logic [Adr_size-1:0] adr_d;
   logic                wr_d;
   logic                rd_d;
   logic [Dta_size-1:0] wdata_d;
   logic                seq_end_d;

   logic                elem_single;
   logic                elem_desc;
   logic                adr_last;
   logic [Dta_size-1:0] exp_rd;
   logic                mismatch;

   assign adress    = adr_q;
   assign wr_en     = wr_q;
   assign read_en   = rd_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign fail      = fail_q;
   assign fail_adr  = fail_adr_q;
   assign fail_data = fail_data_q;

   assign data = wr_q ? wdata_q : 'z;

   always_comb begin
      elem_single = (elem_q == E0) || (elem_q == E5);
      elem_desc   = (elem_q == E3) || (elem_q == E4);
      adr_last    = elem_desc ? (adr_q == '0) : (adr_q == '1);
      exp_rd      = ((elem_q == E2) || (elem_q == E4)) ? '1 : '0;
      mismatch    = rd_q && (data != exp_rd);

      elem_d    = elem_q;
      op2_d     = 1'b0;
      adr_d     = adr_q;
      wr_d      = 1'b0;
      rd_d      = 1'b0;
      wdata_d   = '0;
      seq_end_d = 1'b0;

      if (!op2_q && !elem_single) begin
         // read done, now write the complementary pattern at the same address
         op2_d   = 1'b1;
         wr_d    = 1'b1;
         wdata_d = ((elem_q == E1) || (elem_q == E3)) ? '1 : '0;
      end else if (!adr_last) begin
         adr_d = elem_desc ? adr_q - 1'b1 : adr_q + 1'b1;
         wr_d  = (elem_q == E0);
         rd_d  = (elem_q != E0);
      end else if (elem_q == E5) begin
         seq_end_d = 1'b1;
      end else begin
         // Every element after E0 starts with a read. E3/E4 descend from
         // N-1; the others ascend from 0.
         elem_d = elem_e'(elem_q + 3'd1);
         adr_d  = ((elem_d == E3) || (elem_d == E4)) ? '1 : '0;
         rd_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         elem_q      <= E0;
         op2_q       <= 1'b0;
         adr_q       <= '0;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         wdata_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_adr_q  <= '0;
         fail_data_q <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q     <= RUN;
                  elem_q      <= E0;
                  op2_q       <= 1'b0;
                  adr_q       <= '0;
                  wr_q        <= 1'b1;
                  rd_q        <= 1'b0;
                  wdata_q     <= '0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  fail_q      <= 1'b0;
                  fail_adr_q  <= '0;
                  fail_data_q <= '0;
               end
            end
            RUN: begin
               if (mismatch && !fail_q) begin
                  fail_q      <= 1'b1;
                  fail_adr_q  <= adr_q;
                  fail_data_q <= data;
               end
`ifdef BIST_STOP_ON_FAIL_EN
               if (mismatch) begin
                  state_q <= DONE;
                  wr_q    <= 1'b0;
                  rd_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else
`endif
               if (seq_end_d) begin
                  state_q <= DONE;
                  adr_q   <= '0;
                  wr_q    <= 1'b0;
                  rd_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  elem_q  <= elem_d;
                  op2_q   <= op2_d;
                  adr_q   <= adr_d;
                  wr_q    <= wr_d;
                  rd_q    <= rd_d;
                  wdata_q <= wdata_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_march_bist_ctrl.sv
`timescale 1ns/1ps
module tb_march_bist_ctrl;
   localparam int AW = 4;
   localparam int DW = 8;
   localparam int N  = 1 << AW;

   typedef struct {
      bit            wr;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
   } op_t;

   typedef struct {
      bit            fail;
      logic [AW-1:0] fadr;
      logic [DW-1:0] fdat;
      int            cycles;
      logic [AW-1:0] end_adr;
   } res_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] adress;
   wire  [DW-1:0] data;
   logic          wr_en;
   logic          read_en;
   logic          busy;
   logic          done;
   logic          fail;
   logic [AW-1:0] fail_adr;
   logic [DW-1:0] fail_data;

   logic [DW-1:0] mem [N];
   bit            fault_on = 1'b0;
   int unsigned   f_word = 0;
   int unsigned   f_bit = 0;
   bit            f_val = 1'b0;

   op_t  opq[$];
   res_t resq[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   march_bist_ctrl #(.Dta_size(DW), .Adr_size(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .adress(adress), .data(data),
      .wr_en(wr_en), .read_en(read_en), .busy(busy), .done(done),
      .fail(fail), .fail_adr(fail_adr), .fail_data(fail_data)
   );

   // RAM model with an optional stuck-at cell
   function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] v);
      logic [DW-1:0] r;
      r = v;
      if (fault_on && a == f_word[AW-1:0]) r[f_bit] = f_val;
      return r;
   endfunction

   always @(posedge clk) if (wr_en) mem[adress] <= data;
   assign data = read_en ? faulty(adress, mem[adress]) : 'z;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: March C- walked element by element over a plain array
   task automatic push_expected();
      logic [DW-1:0] m [N];
      int  nops [6]    = '{1, 2, 2, 2, 2, 1};
      bit  iswr [6][2] = '{'{1,0}, '{0,1}, '{0,1}, '{0,1}, '{0,1}, '{0,0}};
      bit  val  [6][2] = '{'{0,0}, '{0,1}, '{1,0}, '{0,1}, '{1,0}, '{0,0}};
      bit  dsc  [6]    = '{0, 0, 0, 1, 1, 0};
      bit  stop = 1'b0;
      res_t r;
      op_t  o;
      logic [DW-1:0] pat, rv;
      int a;
      r.fail = 1'b0; r.fadr = '0; r.fdat = '0; r.cycles = 0; r.end_adr = '0;
      for (int e = 0; e < 6 && !stop; e++)
         for (int k = 0; k < N && !stop; k++) begin
            a = dsc[e] ? N - 1 - k : k;
            for (int p = 0; p < nops[e] && !stop; p++) begin
               pat = val[e][p] ? '1 : '0;
               o.wr = iswr[e][p]; o.adr = a[AW-1:0]; o.dat = pat;
               opq.push_back(o);
               r.cycles++;
               if (o.wr) m[a] = pat;
               else begin
                  rv = faulty(a[AW-1:0], m[a]);
                  if (rv != pat && !r.fail) begin
                     r.fail = 1'b1; r.fadr = a[AW-1:0]; r.fdat = rv;
`ifdef BIST_STOP_ON_FAIL_EN
                     stop = 1'b1; r.end_adr = a[AW-1:0];
`endif
                  end
               end
            end
         end
      resq.push_back(r);
   endtask

   // Monitor: pops expected operations and results as the DUT presents them
   initial begin : monitor
      bit   busy_p = 1'b0;
      bit   done_p = 1'b0;
      int   cyc = 0;
      op_t  o;
      res_t r;
      forever begin
         @(negedge clk);
         chk("no_contention", {31'd0, wr_en & read_en}, 0);
         if (busy && !busy_p) cyc = 1;
         else if (busy) cyc++;
         if (wr_en || read_en) begin
            if (opq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_access: adress %0h wr_en %0b read_en %0b, none expected", adress, wr_en, read_en);
            end else begin
               o = opq.pop_front();
               chk("op_is_write", {31'd0, wr_en}, {31'd0, o.wr});
               chk("op_adress", {28'd0, adress}, {28'd0, o.adr});
               chk("op_busy", {31'd0, busy}, 1);
               if (wr_en) chk("write_data", {24'd0, data}, {24'd0, o.dat});
            end
         end
         if (done && !done_p) begin
            if (resq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: done rose with no run pending");
            end else begin
               r = resq.pop_front();
               chk("res_fail", {31'd0, fail}, {31'd0, r.fail});
               chk("res_fail_adr", {28'd0, fail_adr}, {28'd0, r.fadr});
               chk("res_fail_data", {24'd0, fail_data}, {24'd0, r.fdat});
               chk("res_busy_cycles", cyc, r.cycles);
               chk("res_end_adress", {28'd0, adress}, {28'd0, r.end_adr});
               chk("res_busy_low", {31'd0, busy}, 0);
               chk("res_ops_left", opq.size(), 0);
            end
         end
         busy_p = busy;
         done_p = done;
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_adress"}, {28'd0, adress}, 0);
      chk({tag, "_wr_en"}, {31'd0, wr_en}, 0);
      chk({tag, "_read_en"}, {31'd0, read_en}, 0);
      chk({tag, "_busy"}, {31'd0, busy}, 0);
      chk({tag, "_done"}, {31'd0, done}, 0);
      chk({tag, "_fail"}, {31'd0, fail}, 0);
      chk({tag, "_fail_adr"}, {28'd0, fail_adr}, 0);
      chk({tag, "_fail_data"}, {24'd0, fail_data}, 0);
   endtask

   // Pulse start; returns at the negedge of cycle 1
   task automatic launch();
      push_expected();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("start_busy", {31'd0, busy}, 1);
      chk("start_clr_done", {31'd0, done}, 0);
      chk("start_clr_fail", {31'd0, fail}, 0);
      chk("start_clr_fail_adr", {28'd0, fail_adr}, 0);
      chk("start_clr_fail_data", {24'd0, fail_data}, 0);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 12 * N && !done; i++) @(negedge clk);
      chk("done_timeout", {31'd0, done}, 1);
      repeat (6) @(negedge clk);
   endtask

   task automatic set_fault(input bit on, input int unsigned w, input int unsigned b, input bit v);
      fault_on = on; f_word = w; f_bit = b; f_val = v;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      rst = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("por");
      rst = 1'b0;
      @(negedge clk);

      // clean run with an ignored start around cycle 50
      set_fault(0, 0, 0, 0);
      launch();
      repeat (48) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done();
      chk("clean_fail", {31'd0, fail}, 0);

      // word 5 bit 3 stuck at 1
      set_fault(1, 5, 3, 1);
      launch();
      wait_done();
      chk("sa1_fail", {31'd0, fail}, 1);
      chk("sa1_fail_adr", {28'd0, fail_adr}, 32'h5);
      chk("sa1_fail_data", {24'd0, fail_data}, 32'h08);

      // clean run from DONE with fail set: flags must clear at start
      set_fault(0, 0, 0, 0);
      launch();
      wait_done();

      // randomized stuck-at cells
      for (int t = 0; t < 6; t++) begin
         set_fault(1, $urandom_range(0, N - 1), $urandom_range(0, DW - 1), 1'($urandom_range(0, 1)));
         launch();
         wait_done();
      end

      // reset during a run
      set_fault(0, 0, 0, 0);
      launch();
      repeat (68) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      opq.delete();
      resq.delete();
      @(negedge clk);
      check_reset("midrst");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      launch();
      wait_done();
      chk("post_rst_fail", {31'd0, fail}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
